// File: rtl/contrast_level_ctrl.sv
// Front-panel contrast controller: debounced up/down/default keys set a
// target level that is applied to the datapath only on frame boundaries.
module contrast_level_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int DEFAULT_LEVEL   = 8,
  parameter bit RAMP_EN         = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_default,
  input  logic       frame_start,
  output logic [3:0] contrast_level,
  output logic [3:0] target_level,
  output logic       level_changing
);

  localparam int DB = (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
  localparam int RD = (REPEAT_DELAY < 1) ? 1 : REPEAT_DELAY;
  localparam int RP = (REPEAT_PERIOD < 1) ? 1 : REPEAT_PERIOD;
  localparam bit REP_ON = (REPEAT_PERIOD != 0);
  localparam int M1 = (DB > RD) ? DB : RD;
  localparam int MX = (M1 > RP) ? M1 : RP;
  localparam int CW = $clog2(MX + 1);

  localparam logic [CW-1:0] DB_END = CW'(DB - 1);
  localparam logic [CW-1:0] RD_END = CW'(RD - 1);
  localparam logic [CW-1:0] RP_END = CW'(RP - 1);
  localparam logic [3:0]    DEF    = 4'(DEFAULT_LEVEL);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } db_state_t;

  // index 0 = up, 1 = down, 2 = default
  logic [2:0]    s1;
  logic [2:0]    s2;
  db_state_t     st    [3];
  logic [CW-1:0] cnt   [3];
  logic [CW-1:0] rcnt  [3];
  logic [2:0]    first;

  logic [2:0] press;
  logic [2:0] rep;
  logic       ev_up;
  logic       ev_dn;
  logic       ev_def;
  logic [3:0] t_nx;
  logic [3:0] c_nx;

  always_comb begin
    press = '0;
    rep   = '0;
    for (int i = 0; i < 3; i++) begin
      press[i] = (st[i] == PRESS_WAIT) && s2[i]
               && (cnt[i] == DB_END);
      if (REP_ON && i != 2)
        rep[i] = (st[i] == HELD) && s2[i]
               && (rcnt[i] == (first[i] ? RD_END : RP_END));
    end
  end

  assign ev_up  = press[0] | rep[0];
  assign ev_dn  = press[1] | rep[1];
  assign ev_def = press[2];

  always_comb begin
    t_nx = target_level;
    unique case (1'b1)
      ev_def: t_nx = DEF;
      ev_up && !ev_dn: begin
        if (target_level != 4'hF)
          t_nx = target_level + 4'd1;
      end
      ev_dn && !ev_up: begin
        if (target_level != 4'h0)
          t_nx = target_level - 4'd1;
      end
      default: ;
    endcase
  end

  // Apply uses the pre-update target so a frame never sees a half-step.
  always_comb begin
    c_nx = contrast_level;
    if (frame_start && contrast_level != target_level) begin
      if (!RAMP_EN)
        c_nx = target_level;
      else if (target_level > contrast_level)
        c_nx = contrast_level + 4'd1;
      else
        c_nx = contrast_level - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= '0;
      s2    <= '0;
      first <= '0;
      for (int i = 0; i < 3; i++) begin
        st[i]   <= RELEASED;
        cnt[i]  <= '0;
        rcnt[i] <= '0;
      end
    end else begin
      s1 <= {btn_default, btn_down, btn_up};
      s2 <= s1;
      for (int i = 0; i < 3; i++) begin
        unique case (st[i])
          RELEASED: begin
            if (s2[i]) begin
              st[i]  <= PRESS_WAIT;
              cnt[i] <= '0;
            end
          end
          PRESS_WAIT: begin
            if (!s2[i]) begin
              st[i] <= RELEASED;
            end else if (cnt[i] == DB_END) begin
              st[i]    <= HELD;
              rcnt[i]  <= '0;
              first[i] <= 1'b1;
            end else begin
              cnt[i] <= cnt[i] + 1'b1;
            end
          end
          HELD: begin
            if (!s2[i]) begin
              st[i]  <= RELEASE_WAIT;
              cnt[i] <= '0;
            end else if (REP_ON && i != 2) begin
              if (rep[i]) begin
                rcnt[i]  <= '0;
                first[i] <= 1'b0;
              end else begin
                rcnt[i] <= rcnt[i] + 1'b1;
              end
            end
          end
          RELEASE_WAIT: begin
            if (s2[i]) begin
              st[i]    <= HELD;
              rcnt[i]  <= '0;
              first[i] <= 1'b1;
            end else if (cnt[i] == DB_END) begin
              st[i] <= RELEASED;
            end else begin
              cnt[i] <= cnt[i] + 1'b1;
            end
          end
          default: st[i] <= RELEASED;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      contrast_level <= DEF;
      target_level   <= DEF;
      level_changing <= 1'b0;
    end else begin
      contrast_level <= c_nx;
      target_level   <= t_nx;
      level_changing <= (c_nx != t_nx);
    end
  end

endmodule
